// File: rtl/lcd_bus_pkg.sv
// Shared constants and types for the 8080-style LCD bus responder.
package lcd_bus_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_RDID    = 8'h04;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CASET  = 3'd1;
  localparam state_t ST_PASET  = 3'd2;
  localparam state_t ST_RAMWR  = 3'd3;
  localparam state_t ST_IGNORE = 3'd4;

  typedef struct packed {
    logic       cd;
    logic [7:0] data;
  } bus_byte_t;

  function automatic logic [8:0] clamp_addr(input logic [15:0] v, input logic [8:0] lim);
    return (v > {7'd0, lim}) ? lim : v[8:0];
  endfunction

endpackage

// File: rtl/lcd_bus_responder_sync.sv
// Two-flop synchronizers for the asynchronous LCD bus plus write/read/cs edge pulses.
module lcd_bus_sync
  import lcd_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       cd,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] data_in,
  output logic       wr_evt,
  output logic       rd_fall,
  output logic       rd_rise,
  output logic       cs_rise,
  output bus_byte_t  bus
);

  // [1] is the synchronized level; strobes idle high so reset cannot fake an edge
  logic [1:0] cs_sh, wr_sh, rd_sh;
  logic       cs_q, wr_q, rd_q;
  bus_byte_t  b_s1, b_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sh <= 2'b11;
      wr_sh <= 2'b11;
      rd_sh <= 2'b11;
      cs_q  <= 1'b1;
      wr_q  <= 1'b1;
      rd_q  <= 1'b1;
      b_s1  <= '0;
      b_s2  <= '0;
    end else begin
      cs_sh <= {cs_sh[0], cs_n};
      wr_sh <= {wr_sh[0], wr_n};
      rd_sh <= {rd_sh[0], rd_n};
      cs_q  <= cs_sh[1];
      wr_q  <= wr_sh[1];
      rd_q  <= rd_sh[1];
      b_s1  <= {cd, data_in};
      b_s2  <= b_s1;
    end
  end

  assign wr_evt  = wr_sh[1] & ~wr_q & ~cs_sh[1];
  assign rd_fall = ~rd_sh[1] & rd_q & ~cs_sh[1];
  assign rd_rise = rd_sh[1] & ~rd_q;
  assign cs_rise = cs_sh[1] & ~cs_q;
  assign bus     = b_s2;

endmodule

// File: rtl/lcd_bus_responder.sv
// ILI9341-style panel front end: command decode, address window, RGB565 pixel stream.
// Optional ID read-back is enabled by defining LCD_RESPONDER_READBACK_EN.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int          COLS     = 320,
  parameter int          ROWS     = 240,
  parameter logic [23:0] PANEL_ID = 24'h009341
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        cd,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color
);

  localparam logic [8:0] XMAX = 9'(COLS - 1);
  localparam logic [8:0] YMAX = 9'(ROWS - 1);
  localparam int STAGES = 1;

  logic       wr_evt, rd_fall, rd_rise, cs_rise;
  bus_byte_t  bus;

  state_t      state;
  logic [1:0]  pcnt;
  logic [15:0] p_start;
  logic [7:0]  p_end_hi;
  logic [8:0]  sc, ec, sp, ep, cur_x, cur_y;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [STAGES:0] vld_pipe;
  logic [8:0]  stg_x, stg_y;
  logic [15:0] stg_color;

  logic [8:0]  lim, c_start, c_end;
  logic        pix_done;

  lcd_bus_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .cs_n    (cs_n),
    .cd      (cd),
    .wr_n    (wr_n),
    .rd_n    (rd_n),
    .data_in (data_in),
    .wr_evt  (wr_evt),
    .rd_fall (rd_fall),
    .rd_rise (rd_rise),
    .cs_rise (cs_rise),
    .bus     (bus)
  );

  // Commit values for the 4th window parameter, which is the byte on the bus now
  always_comb begin
    lim     = (state == ST_PASET) ? YMAX : XMAX;
    c_start = clamp_addr(p_start, lim);
    c_end   = clamp_addr({p_end_hi, bus.data}, lim);
    if (c_end < c_start) c_end = c_start;
  end

  assign pix_done = wr_evt & bus.cd & (state == ST_RAMWR) & phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      p_start    <= '0;
      p_end_hi   <= '0;
      sc         <= '0;
      ec         <= XMAX;
      sp         <= '0;
      ep         <= YMAX;
      cur_x      <= '0;
      cur_y      <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      cmd_strobe <= 1'b0;
      cmd_code   <= '0;
      stg_x      <= '0;
      stg_y      <= '0;
      stg_color  <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      if (cs_rise) phase <= 1'b0;
      if (wr_evt && !bus.cd) begin
        cmd_strobe <= 1'b1;
        cmd_code   <= bus.data;
        pcnt       <= '0;
        phase      <= 1'b0;
        case (bus.data)
          CMD_CASET: state <= ST_CASET;
          CMD_PASET: state <= ST_PASET;
          CMD_RAMWR: begin
            state <= ST_RAMWR;
            cur_x <= sc;
            cur_y <= sp;
          end
          CMD_SWRESET: begin
            state <= ST_IDLE;
            sc    <= '0;
            ec    <= XMAX;
            sp    <= '0;
            ep    <= YMAX;
          end
          default: state <= ST_IGNORE;
        endcase
      end else if (wr_evt) begin
        case (state)
          ST_CASET, ST_PASET: begin
            pcnt <= pcnt + 2'd1;
            case (pcnt)
              2'd0: p_start[15:8] <= bus.data;
              2'd1: p_start[7:0]  <= bus.data;
              2'd2: p_end_hi      <= bus.data;
              default: begin
                if (state == ST_CASET) begin
                  sc <= c_start;
                  ec <= c_end;
                end else begin
                  sp <= c_start;
                  ep <= c_end;
                end
                state <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!phase) begin
              hi_byte <= bus.data;
              phase   <= 1'b1;
            end else begin
              phase     <= 1'b0;
              stg_x     <= cur_x;
              stg_y     <= cur_y;
              stg_color <= {hi_byte, bus.data};
              if (cur_x == ec) begin
                cur_x <= sc;
                cur_y <= (cur_y == ep) ? sp : cur_y + 9'd1;
              end else begin
                cur_x <= cur_x + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Extra stage puts the pixel one cycle behind the command strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], pix_done};
      if (vld_pipe[0]) begin
        pix_x     <= stg_x;
        pix_y     <= stg_y;
        pix_color <= stg_color;
      end
    end
  end

  assign pix_valid = vld_pipe[STAGES];

`ifdef LCD_RESPONDER_READBACK_EN
  logic       rb_armed;
  logic [2:0] rb_idx;
  logic [7:0] rb_byte;

  always_comb begin
    case (rb_idx)
      3'd1:    rb_byte = PANEL_ID[23:16];
      3'd2:    rb_byte = PANEL_ID[15:8];
      3'd3:    rb_byte = PANEL_ID[7:0];
      default: rb_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_armed <= 1'b0;
      rb_idx   <= '0;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      if (wr_evt && !bus.cd) begin
        rb_armed <= (bus.data == CMD_RDID);
        rb_idx   <= '0;
      end
      if (rd_fall && rb_armed) begin
        data_oe  <= 1'b1;
        data_out <= rb_byte;
        if (rb_idx != 3'd4) rb_idx <= rb_idx + 3'd1;
      end else if (rd_rise) begin
        data_oe <= 1'b0;
      end
    end
  end
`else
  logic rd_unused;
  assign rd_unused = rd_fall ^ rd_rise;
  assign data_out  = '0;
  assign data_oe   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized self-checking bench for lcd_bus_responder against a byte-stream panel model.
module tb_lcd_bus_responder;
  localparam int          COLS = 320;
  localparam int          ROWS = 240;
  localparam logic [23:0] PID  = 24'h009341;

  logic clk = 1'b0, rst = 1'b0, cs_n = 1'b1, cd = 1'b0, wr_n = 1'b1, rd_n = 1'b1;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out, cmd_code;
  logic        data_oe, cmd_strobe, pix_valid;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;

  lcd_bus_responder #(.COLS(COLS), .ROWS(ROWS), .PANEL_ID(PID)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .cd(cd), .wr_n(wr_n), .rd_n(rd_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0, errors = 0;
  int   cmd_cnt = 0, pix_cnt = 0;
  logic [4:0] cs_hist, pv_hist;

  // Panel model: mode 0 idle, 1 column params, 2 page params, 3 pixel write, 4 ignore
  int m_mode, m_pcnt, m_x, m_y, m_phase, m_hi;
  int m_win[4];
  int m_par[4];

  function automatic void model_reset();
    m_mode = 0; m_pcnt = 0; m_phase = 0; m_hi = 0;
    m_win[0] = 0; m_win[1] = COLS - 1; m_win[2] = 0; m_win[3] = ROWS - 1;
  endfunction

  function automatic void model_write(input logic c, input logic [7:0] d);
    int lim, s, e, base;
    pix_t p;
    if (!c) begin
      m_phase = 0; m_pcnt = 0;
      case (d)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_x = m_win[0]; m_y = m_win[2]; end
        8'h01: begin model_reset(); end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_pcnt] = int'(d);
      m_pcnt++;
      if (m_pcnt == 4) begin
        lim  = (m_mode == 1) ? COLS - 1 : ROWS - 1;
        base = (m_mode == 1) ? 0 : 2;
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        if (s > lim) s = lim;
        if (e > lim) e = lim;
        if (e < s) e = s;
        m_win[base] = s; m_win[base+1] = e;
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_phase == 0) begin
        m_hi = int'(d); m_phase = 1;
      end else begin
        p.x = m_x; p.y = m_y; p.c = m_hi * 256 + int'(d);
        exp_q.push_back(p);
        m_phase = 0;
        if (m_x == m_win[1]) begin
          m_x = m_win[0];
          m_y = (m_y == m_win[3]) ? m_win[2] : m_y + 1;
        end else m_x++;
      end
    end
  endfunction

  task automatic send(input logic c, input logic [7:0] d);
    model_write(c, d);
    @(posedge clk); #2;
    cd = c; data_in = d; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 wr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cs_hist[k] = cmd_strobe;
      pv_hist[k] = pix_valid;
    end
  endtask

  task automatic cs_pulse();
    m_phase = 0;
    @(posedge clk); #2 cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #2 cs_n = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Scoreboard: every pixel pulse must match the next modelled pixel
  always @(posedge clk) begin
    #1;
    if (cmd_strobe) cmd_cnt++;
    if (pix_valid) begin
      pix_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_pixel got (%0d,%0d,%h) want none", pix_x, pix_y, pix_color);
      end else begin
        mon_e = exp_q.pop_front();
        if (pix_x !== 9'(mon_e.x) || pix_y !== 9'(mon_e.y) || pix_color !== 16'(mon_e.c)) begin
          errors++;
          $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                   pix_x, pix_y, pix_color, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_out, data_oe, cmd_strobe, cmd_code} !== 18'd0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", {data_out, data_oe, cmd_strobe, cmd_code});
    end
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_color} !== 35'd0) begin
      errors++; $display("FAIL reset_pix got %h want 0", {pix_valid, pix_x, pix_y, pix_color});
    end
    @(negedge clk) rst = 1'b1;
    cs_n = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
  endtask

  task automatic test_first_pixel();
    send(1'b0, 8'h2C);
    checks++;
    if (cs_hist !== 5'b00100) begin
      errors++; $display("FAIL cmd_latency got %b want 00100", cs_hist);
    end
    checks++;
    if (cmd_code !== 8'h2C) begin
      errors++; $display("FAIL cmd_code got %h want 2c", cmd_code);
    end
    send(1'b1, 8'hF8);
    checks++;
    if (pv_hist !== 5'b00000) begin
      errors++; $display("FAIL half_pixel got %b want 00000", pv_hist);
    end
    send(1'b1, 8'h00);
    checks++;
    if (pv_hist !== 5'b01000) begin
      errors++; $display("FAIL pix_latency got %b want 01000", pv_hist);
    end
    checks++;
    if ({pix_x, pix_y, pix_color} !== {9'd0, 9'd0, 16'hF800}) begin
      errors++; $display("FAIL first_pixel got (%0d,%0d,%h) want (0,0,f800)", pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_window();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0B);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'($urandom));
      send(1'b1, 8'($urandom));
    end
    checks++;
    if (pix_x !== 9'd10 || pix_y !== 9'd5) begin
      errors++; $display("FAIL window_wrap got (%0d,%0d) want (10,5)", pix_x, pix_y);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL window_missing got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_clamp();
    send(1'b0, 8'h2A); send(1'b1, 8'h01); send(1'b1, 8'hF4); send(1'b1, 8'h00); send(1'b1, 8'h02);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'($urandom));
      send(1'b1, 8'($urandom));
    end
    checks++;
    if (pix_x !== 9'd319 || pix_y !== 9'd5) begin
      errors++; $display("FAIL clamp got (%0d,%0d) want (319,5)", pix_x, pix_y);
    end
  endtask

  task automatic test_cs_discard();
    int p0;
    send(1'b0, 8'h2C);
    p0 = pix_cnt;
    send(1'b1, 8'h55);
    cs_pulse();
    send(1'b1, 8'h12);
    send(1'b1, 8'h34);
    checks++;
    if (pix_cnt - p0 != 1 || pix_color !== 16'h1234) begin
      errors++; $display("FAIL cs_discard got %0d pixels color %h want 1 pixel color 1234", pix_cnt - p0, pix_color);
    end
  endtask

  task automatic test_interrupt();
    int c0;
    c0 = cmd_cnt;
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h01); send(1'b0, 8'h2C);
    checks++;
    if (cmd_cnt - c0 != 2 || cmd_code !== 8'h2C) begin
      errors++; $display("FAIL interrupt got %0d strobes code %h want 2 strobes code 2c", cmd_cnt - c0, cmd_code);
    end
    send(1'b1, 8'hAA); send(1'b1, 8'h55);
    checks++;
    if (pix_x !== 9'd319 || pix_y !== 9'd5) begin
      errors++; $display("FAIL interrupt_window got (%0d,%0d) want (319,5)", pix_x, pix_y);
    end
  endtask

  task automatic test_swreset();
    send(1'b0, 8'h01); send(1'b0, 8'h2C);
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 8'($urandom));
      send(1'b1, 8'($urandom));
    end
    checks++;
    if (pix_x !== 9'd1 || pix_y !== 9'd0) begin
      errors++; $display("FAIL swreset got (%0d,%0d) want (1,0)", pix_x, pix_y);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds [4];
    cmds[0] = 8'h11; cmds[1] = 8'h29; cmds[2] = 8'h04; cmds[3] = 8'h01;
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 2; w++) begin
        send(1'b0, w == 0 ? 8'h2A : 8'h2B);
        for (int p = 0; p < 4; p++) begin
          if (p == 3 && $urandom_range(5) == 0) break;
          send(1'b1, (p % 2 == 0) ? 8'($urandom_range(1)) : 8'($urandom));
        end
      end
      if ($urandom_range(3) == 0) send(1'b1, 8'($urandom));
      send(1'b0, 8'h2C);
      for (int b = 0, n = $urandom_range(12, 1); b < n; b++) begin
        if ($urandom_range(7) == 0) cs_pulse();
        send(1'b1, 8'($urandom));
      end
      if ($urandom_range(3) == 0) begin
        send(1'b0, cmds[$urandom_range(3)]);
        send(1'b1, 8'($urandom));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_missing got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({cmd_code, pix_x, pix_y, pix_color} !== 42'd0) begin
      errors++; $display("FAIL reset_mid got %h want 0", {cmd_code, pix_x, pix_y, pix_color});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34);
    checks++;
    if ({pix_x, pix_y, pix_color} !== {9'd0, 9'd0, 16'h1234}) begin
      errors++; $display("FAIL reset_mid_pixel got (%0d,%0d,%h) want (0,0,1234)", pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_readback();
    logic [7:0] rb_exp [5];
    rb_exp[0] = 8'h00; rb_exp[1] = PID[23:16]; rb_exp[2] = PID[15:8]; rb_exp[3] = PID[7:0]; rb_exp[4] = 8'h00;
`ifdef LCD_RESPONDER_READBACK_EN
    send(1'b0, 8'h04);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2 rd_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (data_oe !== 1'b1 || data_out !== rb_exp[i]) begin
        errors++; $display("FAIL readback_%0d got oe=%b %h want oe=1 %h", i, data_oe, data_out, rb_exp[i]);
      end
      rd_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (data_oe !== 1'b0) begin
        errors++; $display("FAIL readback_release_%0d got oe=%b want 0", i, data_oe);
      end
    end
`else
    send(1'b0, 8'h04);
    @(posedge clk); #2 rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (data_oe !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL no_readback got oe=%b %h want oe=0 00 (id byte %h unused)", data_oe, data_out, rb_exp[1]);
    end
    rd_n = 1'b1;
    repeat (4) @(posedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_window();
    test_clamp();
    test_cs_discard();
    test_interrupt();
    test_swreset();
    test_random();
    test_readback();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Display-side responder for the 8080-style parallel LCD bus (`cs`, `cd`, `wr`, `rd`, `data`) that the game's parallel display controller drives. It decodes the command/parameter/pixel byte stream like an ILI9341-class panel: it tracks the column and page address window and emits one addressed RGB565 pixel per completed two-byte write. It serves as the panel model in system benches and as the front end of an on-FPGA frame-buffer emulation of the display.

## Interface
- `COLS`, default 320: panel width in pixels; column addresses clamp to `COLS-1`.
- `ROWS`, default 240: panel height in pixels; page addresses clamp to `ROWS-1`.
- `PANEL_ID`, default 24'h009341: ID returned by read-back.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cs_n` in 1: chip select, active-low, asynchronous to `clk`.
- `cd` in 1: 0 = command byte, 1 = data/parameter byte.
- `wr_n` in 1: write strobe, active-low; byte taken on rising edge.
- `rd_n` in 1: read strobe, active-low.
- `data_in` in 8: bus byte.
- `data_out` out 8: read-back byte.
- `data_oe` out 1: drive enable for `data_out`.
- `cmd_strobe` out 1: one-cycle pulse per received command byte.
- `cmd_code` out 8: last command byte.
- `pix_valid` out 1: one-cycle pulse per completed pixel.
- `pix_x` out 9: column of the pixel.
- `pix_y` out 9: page of the pixel.
- `pix_color` out 16: RGB565 value, first byte in `[15:8]`.

## Operation
- All bus inputs pass through 2-flop synchronizers. A write event is a sampled `wr_n` 0->1 while sampled `cs_n`=0. The event uses the `cd`/`data_in` values sampled in the same cycle.
- States: `IDLE`, `CASET` (4 params), `PASET` (4 params), `RAMWR`, `IGNORE`.
- Any event with `cd`=0 pulses `cmd_strobe`, loads `cmd_code`, and selects the next state from any state: 0x2A->`CASET`, 0x2B->`PASET`, 0x2C->`RAMWR`, 0x01->`IDLE`, others->`IGNORE`.
- 0x01 (SWRESET) also restores the window to 0..COLS-1 / 0..ROWS-1.
- 0x2C loads the cursor to (SC,SP) and clears the byte phase.
- `CASET`/`PASET` params, in order: start[15:8], start[7:0], end[15:8], end[7:0].
  - Values are committed after the 4th param, then state goes to `IDLE`.
  - Commit clamps each value to the `COLS-1`/`ROWS-1` limit. If end < start, end is forced to start.
  - Extra params go to `IGNORE`.
- `RAMWR`: even-phase byte is latched as the high byte. The odd-phase byte completes the pixel: `pix_valid`=1 with the current cursor, then the cursor advances.
  - x increments. If x == EC, x wraps to SC and y increments.
  - If y == EP at that wrap, y wraps to SP.
- `cd`=1 bytes in `IDLE`/`IGNORE` are discarded.
- A sampled `cs_n` 0->1 discards a pending high byte (phase back to even). It does not change the state or the window.

## Timing
- Reset values: `data_out`=0, `data_oe`=0, `cmd_strobe`=0, `cmd_code`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_color`=0. Window is 0..COLS-1 / 0..ROWS-1; state is `IDLE`; byte phase is even.
- The bus must hold each `wr_n`/`rd_n` level for at least 3 `clk` cycles, with `data_in`/`cd` stable through the `wr_n` rising edge plus 3 cycles.
- Latency from the pin `wr_n` rising edge:
  - `cmd_strobe`: asserted exactly 3 cycles later.
  - `pix_valid`: asserted exactly 4 cycles later.
  - `pix_x`/`pix_y`/`pix_color` are held until the next pixel.
- Reset asserted mid-pixel or mid-param returns everything to reset values immediately; partial data is lost.

## Configuration
- `LCD_RESPONDER_READBACK_EN` defined:
  - Command 0x04 arms read-back.
  - Each sampled `rd_n` 1->0 with `cs_n`=0 sets `data_oe`=1 and presents the next byte: dummy 0x00, then `PANEL_ID[23:16]`, `[15:8]`, `[7:0]`, then 0x00 thereafter.
  - `data_oe` drops on the sampled `rd_n` rise.
- Not defined: `rd_n` is ignored, `data_oe` and `data_out` are tied to 0, and 0x04 is treated as an `IGNORE` command.

## Structure
- Package `lcd_bus_pkg`: command constants (0x01, 0x04, 0x2A, 0x2B, 0x2C) and the state enum.
- Sub-module `lcd_bus_sync`: synchronizes `cs_n`/`cd`/`wr_n`/`rd_n`/`data_in` and produces the write/read edge pulses. All decode stays in the top.

## Test plan
- Reset, then 0x2C followed by bytes F8,00 -> one `pix_valid` with (0,0), color 0xF800.
- 0x2A 00,0A,00,0B; 0x2B 00,05,00,06; 0x2C; 5 pixels -> (10,5), (11,5), (10,6), (11,6), (10,5).
- 0x2A 01,F4,00,02 -> window clamps to SC=EC=319; pixels repeat at x=319 while y advances.
- High byte sent, `cs_n` pulsed high, then 0x12,0x34 -> a single pixel with color 0x1234; no stray pixel.
- 0x2A 00,01 followed by 0x2C (interrupting the params) -> window unchanged; `cmd_strobe` pulses twice; `cmd_code`=0x2C.
- With `LCD_RESPONDER_READBACK_EN`: 0x04 followed by 4 reads -> 00, 00, 93, 41 with `data_oe` high during each `rd_n` low.
